// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory req/ack port, decoder
// valid/ready hand-off, execute redirect input and the hand-off counter.
interface instr_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_count;

  // Fetch stage side
  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_count,
    input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );

  // Memory / decoder / execute side
  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc, fetch_count,
    output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a
// req/ack memory port, holds it for the decoder behind valid/ready, and
// squashes wrong-path fetches on a redirect from execute.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  instr_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DROP
  } state_t;

  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] target;

  assign target = bus.redirect_pc & 32'hFFFF_FFFC;

  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.fetch_count = cnt_q;

  // State and registered outputs; reset abandons any outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_A;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC_A;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic; every register holds by default
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        addr_d  = pc_q;
        if (bus.redirect) begin
          pc_d   = target;
          addr_d = target;
        end
      end
      FETCH: begin
        if (bus.mem_ack && bus.redirect) begin
          // ack retires the old request, so the target can go out right away
          pc_d   = target;
          addr_d = target;
        end else if (bus.mem_ack) begin
          instr_d = bus.mem_rdata;
          ipc_d   = addr_q;
          valid_d = 1'b1;
          pc_d    = addr_q + 32'd4;
          req_d   = 1'b0;
          state_d = HOLD;
        end else if (bus.redirect) begin
          pc_d    = target;
          state_d = DROP;
        end
      end
      HOLD: begin
        if (bus.instr_ready) begin
          cnt_d = cnt_q + 32'd1;
        end
        if (bus.redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          addr_d  = target;
          req_d   = 1'b1;
          state_d = FETCH;
        end else if (bus.instr_ready) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (bus.mem_ack) begin
          state_d = FETCH;
          if (bus.redirect) begin
            pc_d   = target;
            addr_d = target;
          end else begin
            addr_d = pc_q;
          end
        end else if (bus.redirect) begin
          pc_d = target;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
